axis_out_sink: RTL and testbench

//  Receiving end of the engine output stream (m_axis_* + m_bytes_per_transfer).

---
 rtl/axis_out_sink.sv | 178 +++++++++++++++++
 tb/tb_axis_out_sink.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_out_sink.sv
// axis_out_sink: receiving end of the engine output stream.
// Takes one AXI-stream packet per start and splits each beat into its kept
// OUT_BITS words, lowest lane first. Each word goes to the RAM write port at
// base_addr + n, one word per cycle. done pulses once the packet is fully written.
module axis_out_sink #(
    parameter int M_OUTPUT_WIDTH_LF = 64,
    parameter int OUT_BITS          = 32,
    parameter int OUT_ADDR_WIDTH    = 10,
    parameter int W_BPT             = 4
) (
    input  logic                           aclk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [OUT_ADDR_WIDTH-1:0]      base_addr,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    input  logic [M_OUTPUT_WIDTH_LF-1:0]   s_axis_tdata,
    input  logic [M_OUTPUT_WIDTH_LF/8-1:0] s_axis_tkeep,
    input  logic [W_BPT-1:0]               s_bytes_per_transfer,
    output logic                           mem_wr_en,
    output logic [OUT_ADDR_WIDTH-1:0]      mem_wr_addr,
    output logic [OUT_BITS-1:0]            mem_wr_data,
    output logic [OUT_ADDR_WIDTH:0]        word_count,
    output logic                           done,
    output logic                           err_keep,
    output logic                           err_overflow
);

    localparam int WPB  = M_OUTPUT_WIDTH_LF / OUT_BITS;
    localparam int BPW  = OUT_BITS / 8;
    localparam int KW   = M_OUTPUT_WIDTH_LF / 8;
    localparam int LCW  = $clog2(BPW + 1);
    localparam int KCW0 = $clog2(KW + 1);
    localparam int PCW  = (KCW0 > W_BPT) ? KCW0 : W_BPT;
    localparam logic [OUT_ADDR_WIDTH:0] WC_MAX = {1'b1, {OUT_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DRAIN, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [OUT_ADDR_WIDTH-1:0]      base_q, base_d;
    logic [M_OUTPUT_WIDTH_LF-1:0]   data_q, data_d;
    logic                           last_q, last_d;
    logic [WPB-1:0]                 mask_q, mask_d;
    logic [OUT_ADDR_WIDTH:0]        wcnt_q, wcnt_d;
    logic                           ekeep_q, ekeep_d;
    logic                           eovf_q, eovf_d;

    logic [WPB-1:0]                 beat_mask;
    logic                           keep_bad;
    logic [LCW-1:0]                 lane_cnt;
    logic [PCW-1:0]                 keep_cnt;
    logic [WPB-1:0]                 sel_oh;
    logic [OUT_BITS-1:0]            wr_word;
    logic                           wr_en;

    // Classify the incoming beat: fully kept words, partial words, byte-count check.
    always_comb begin
        beat_mask = '0;
        keep_bad  = 1'b0;
        lane_cnt  = '0;
        keep_cnt  = '0;
        for (int i = 0; i < WPB; i++) begin
            lane_cnt = '0;
            for (int b = 0; b < BPW; b++)
                lane_cnt = lane_cnt + LCW'(s_axis_tkeep[BPW*i + b]);
            beat_mask[i] = (lane_cnt == LCW'(BPW));
            if (lane_cnt != '0 && lane_cnt != LCW'(BPW))
                keep_bad = 1'b1;
        end
        for (int b = 0; b < KW; b++)
            keep_cnt = keep_cnt + PCW'(s_axis_tkeep[b]);
        // Only non-last beats must carry the full advertised byte count.
        if (!s_axis_tlast && keep_cnt != PCW'(s_bytes_per_transfer))
            keep_bad = 1'b1;
    end

    // Pick the lowest pending lane of the latched beat; unset lanes cost nothing.
    always_comb begin
        sel_oh  = '0;
        wr_word = '0;
        for (int i = WPB - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                wr_word   = data_q[OUT_BITS*i +: OUT_BITS];
            end
        end
    end

    // Next-state and handshake/write strobes.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        data_d        = data_q;
        last_d        = last_q;
        mask_d        = mask_q;
        wcnt_d        = wcnt_q;
        ekeep_d       = ekeep_q;
        eovf_d        = eovf_q;
        s_axis_tready = 1'b0;
        wr_en         = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    wcnt_d  = '0;
                    ekeep_d = 1'b0;
                    eovf_d  = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    data_d = s_axis_tdata;
                    last_d = s_axis_tlast;
                    mask_d = beat_mask;
                    if (keep_bad)
                        ekeep_d = 1'b1;
                    // A beat with no whole words has nothing to drain.
                    if (beat_mask == '0)
                        state_d = s_axis_tlast ? S_DONE : S_ACCEPT;
                    else
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                wr_en  = 1'b1;
                mask_d = mask_q & ~sel_oh;
                // Past the RAM size the write still happens at the wrapped address.
                if (wcnt_q == WC_MAX)
                    eovf_d = 1'b1;
                else
                    wcnt_d = wcnt_q + 1'b1;
                if ((mask_q & ~sel_oh) == '0)
                    state_d = last_q ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any beat in flight.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            mask_q  <= '0;
            wcnt_q  <= '0;
            ekeep_q <= 1'b0;
            eovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            data_q  <= data_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            wcnt_q  <= wcnt_d;
            ekeep_q <= ekeep_d;
            eovf_q  <= eovf_d;
        end
    end

    assign mem_wr_en    = wr_en;
    assign mem_wr_addr  = wr_en ? (base_q + wcnt_q[OUT_ADDR_WIDTH-1:0]) : '0;
    assign mem_wr_data  = wr_en ? wr_word : '0;
    assign word_count   = wcnt_q;
    assign err_keep     = ekeep_q;
    assign err_overflow = eovf_q;

endmodule

// File: tb/tb_axis_out_sink.sv
// Directed bench for axis_out_sink (64-bit stream, 32-bit words, 10-bit address).
module tb_axis_out_sink;

    localparam int M  = 64;
    localparam int OB = 32;
    localparam int AW = 10;
    localparam int WB = 4;

    logic          aclk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          s_axis_tready;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic [M-1:0]  s_axis_tdata = '0;
    logic [M/8-1:0] s_axis_tkeep = '0;
    logic [WB-1:0] s_bytes_per_transfer = '0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [OB-1:0] mem_wr_data;
    logic [AW:0]   word_count;
    logic          done;
    logic          err_keep;
    logic          err_overflow;

    axis_out_sink #(.M_OUTPUT_WIDTH_LF(M), .OUT_BITS(OB), .OUT_ADDR_WIDTH(AW), .W_BPT(WB)) dut (
        .aclk(aclk), .reset(reset), .start(start), .base_addr(base_addr),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_bytes_per_transfer(s_bytes_per_transfer),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .word_count(word_count), .done(done), .err_keep(err_keep),
        .err_overflow(err_overflow)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Log of RAM writes, sampled mid-cycle.
    logic [AW-1:0] wa[$];
    logic [OB-1:0] wd[$];
    int            wc[$];
    always @(negedge aclk) begin
        if (mem_wr_en === 1'b1) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
            wc.push_back(cyc);
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    function automatic logic [63:0] fb(input int n);
        logic [31:0] lo, hi;
        lo = 32'hA000_0000 + 32'(2 * n);
        hi = 32'hA000_0000 + 32'(2 * n + 1);
        return {hi, lo};
    endfunction

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
        clr_log();
    endtask

    // Present one beat, wait (bounded) for tready, return just after the handshake edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [3:0] bpt);
        s_axis_tvalid        = 1'b1;
        s_axis_tdata         = d;
        s_axis_tkeep         = k;
        s_axis_tlast         = l;
        s_bytes_per_transfer = bpt;
        for (int n = 0; n < 50 && s_axis_tready !== 1'b1; n++) tick();
        chk("hs_ready", 64'(s_axis_tready), 64'd1);
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        s_axis_tkeep  = 8'hFF;
    endtask

    // Wait (bounded) for the done pulse, note its cycle, then step into IDLE.
    task automatic wait_done(output int dc);
        for (int n = 0; n < 50 && done !== 1'b1; n++) tick();
        chk("done_seen", 64'(done), 64'd1);
        dc = cyc;
        tick();
    endtask

    int dc;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_data", 64'(mem_wr_data), 64'd0);
        chk("rst_wcnt", 64'(word_count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ekeep", 64'(err_keep), 64'd0);
        chk("rst_eovf", 64'(err_overflow), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_tready", 64'(s_axis_tready), 64'd0);

        // 1) three full beats from 0x010
        do_start(10'h010);
        chk("t1_acc_tready", 64'(s_axis_tready), 64'd1);
        send_beat(fb(0), 8'hFF, 1'b0, 4'd8);
        chk("t1_d0_tready", 64'(s_axis_tready), 64'd0);
        chk("t1_d0_wr", 64'(mem_wr_en), 64'd1);
        chk("t1_d0_addr", 64'(mem_wr_addr), 64'h010);
        tick();
        chk("t1_d1_tready", 64'(s_axis_tready), 64'd0);
        chk("t1_d1_data", 64'(mem_wr_data), 64'hA000_0001);
        tick();
        chk("t1_back_tready", 64'(s_axis_tready), 64'd1);
        send_beat(fb(1), 8'hFF, 1'b0, 4'd8);
        send_beat(fb(2), 8'hFF, 1'b1, 4'd8);
        wait_done(dc);
        chk("t1_nwr", 64'(wa.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wa.size()) begin
                chk("t1_addr", 64'(wa[i]), 64'(10'h010 + i));
                chk("t1_data", 64'(wd[i]), 64'(32'hA000_0000 + i));
            end
        end
        if (wc.size() > 0) chk("t1_done_lat", 64'(dc), 64'(wc[wc.size()-1] + 1));
        chk("t1_wcnt", 64'(word_count), 64'd6);
        chk("t1_done_off", 64'(done), 64'd0);
        chk("t1_ekeep", 64'(err_keep), 64'd0);

        // 2) last beat with one kept word
        do_start(10'h020);
        send_beat({32'h2222_2221, 32'h1111_1110}, 8'h0F, 1'b1, 4'd8);
        wait_done(dc);
        chk("t2a_nwr", 64'(wa.size()), 64'd1);
        if (wa.size() > 0) begin
            chk("t2a_addr", 64'(wa[0]), 64'h020);
            chk("t2a_data", 64'(wd[0]), 64'h1111_1110);
        end
        chk("t2a_ekeep", 64'(err_keep), 64'd0);
        do_start(10'h030);
        send_beat({32'h2222_2221, 32'h1111_1110}, 8'hF0, 1'b1, 4'd8);
        wait_done(dc);
        chk("t2b_nwr", 64'(wa.size()), 64'd1);
        if (wa.size() > 0) begin
            chk("t2b_addr", 64'(wa[0]), 64'h030);
            chk("t2b_data", 64'(wd[0]), 64'h2222_2221);
        end
        chk("t2b_ekeep", 64'(err_keep), 64'd0);
        chk("t2b_wcnt", 64'(word_count), 64'd1);

        // 3) partial word on a non-last beat, then byte-count mismatch
        do_start(10'h040);
        send_beat({32'hBBBB_0001, 32'hAAAA_0000}, 8'h3F, 1'b0, 4'd8);
        send_beat(fb(0), 8'hFF, 1'b1, 4'd8);
        wait_done(dc);
        chk("t3_nwr", 64'(wa.size()), 64'd3);
        if (wa.size() == 3) begin
            chk("t3_w0", 64'(wd[0]), 64'hAAAA_0000);
            chk("t3_w1", 64'(wd[1]), 64'hA000_0000);
            chk("t3_a2", 64'(wa[2]), 64'h042);
        end
        chk("t3_ekeep", 64'(err_keep), 64'd1);
        do_start(10'h060);
        chk("t3_ekeep_clr", 64'(err_keep), 64'd0);
        send_beat(fb(0), 8'hFF, 1'b0, 4'd4);
        send_beat(fb(1), 8'hFF, 1'b1, 4'd4);
        wait_done(dc);
        chk("t3b_nwr", 64'(wa.size()), 64'd4);
        chk("t3b_ekeep", 64'(err_keep), 64'd1);

        // 4) address wrap from 0x3FE
        do_start(10'h3FE);
        send_beat(fb(0), 8'hFF, 1'b0, 4'd8);
        send_beat(fb(1), 8'hFF, 1'b1, 4'd8);
        wait_done(dc);
        chk("t4_nwr", 64'(wa.size()), 64'd4);
        if (wa.size() == 4) begin
            chk("t4_a0", 64'(wa[0]), 64'h3FE);
            chk("t4_a1", 64'(wa[1]), 64'h3FF);
            chk("t4_a2", 64'(wa[2]), 64'h000);
            chk("t4_a3", 64'(wa[3]), 64'h001);
        end
        chk("t4_eovf", 64'(err_overflow), 64'd0);
        chk("t4_wcnt", 64'(word_count), 64'd4);

        // 5) 513 full beats -> overflow
        do_start(10'h000);
        for (int b = 0; b < 512; b++) send_beat(fb(b), 8'hFF, 1'b0, 4'd8);
        for (int n = 0; n < 10 && s_axis_tready !== 1'b1; n++) tick();
        chk("t5_wcnt_1024", 64'(word_count), 64'd1024);
        chk("t5_eovf_pre", 64'(err_overflow), 64'd0);
        send_beat(fb(512), 8'hFF, 1'b1, 4'd8);
        wait_done(dc);
        chk("t5_nwr", 64'(wa.size()), 64'd1026);
        chk("t5_wcnt_sat", 64'(word_count), 64'd1024);
        chk("t5_eovf", 64'(err_overflow), 64'd1);
        if (wa.size() == 1026) begin
            chk("t5_a1023", 64'(wa[1023]), 64'h3FF);
            chk("t5_a1024", 64'(wa[1024]), 64'h000);
            chk("t5_a1025", 64'(wa[1025]), 64'h000);
            chk("t5_d1025", 64'(wd[1025]), 64'(32'hA000_0000 + 1025));
        end

        // 6) reset in the middle of the second beat's drain
        do_start(10'h050);
        send_beat(fb(0), 8'hFF, 1'b0, 4'd8);
        send_beat(fb(1), 8'hFF, 1'b0, 4'd8);
        chk("t6_pre_addr", 64'(mem_wr_addr), 64'h052);
        reset = 1'b1;
        tick();
        chk("t6_wr", 64'(mem_wr_en), 64'd0);
        chk("t6_tready", 64'(s_axis_tready), 64'd0);
        chk("t6_addr", 64'(mem_wr_addr), 64'd0);
        chk("t6_data", 64'(mem_wr_data), 64'd0);
        chk("t6_wcnt", 64'(word_count), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        reset = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t6_nostart_tready", 64'(s_axis_tready), 64'd0);
        end
        s_axis_tvalid = 1'b0;
        chk("t6_nwr", 64'(wa.size()), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
